mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential OP_W x OP_W unsigned multiplier controller. It builds the product
// from D*D partial products of 2-bit digits, using one external 2x2 multiplier.
module mult_seq_ctrl #(
    parameter int OP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [OP_W-1:0]     a_in,
    input  logic [OP_W-1:0]     b_in,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W-1:0]   product,
    output logic [1:0]          mul_a,
    output logic [1:0]          mul_b,
    input  logic [3:0]          mul_p,
    output logic [1:0]          state_dbg
);

    // Handshake: start is accepted only while busy=0 (IDLE). A start seen while
    // busy=1 is dropped, not queued. done pulses for one cycle with product valid,
    // and the next start can be presented in the cycle right after done.

    localparam int D     = OP_W / 2;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [OP_W-1:0]     a_reg;
    logic [OP_W-1:0]     b_reg;
    logic [2*OP_W-1:0]   acc;
    logic [2*OP_W-1:0]   term;
    logic [2*OP_W-1:0]   acc_next;
    logic [IDX_W-1:0]    i_idx;
    logic [IDX_W-1:0]    j_idx;
    logic [IDX_W+1:0]    shamt;
    logic                last_step;

    // Digit weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    always_comb begin
        shamt     = {({1'b0, i_idx} + {1'b0, j_idx}), 1'b0};
        term      = '0;
        term[3:0] = mul_p;
        term      = term << shamt;
        acc_next  = acc + term;
        last_step = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);
    end

    always_comb begin
        mul_a = 2'b00;
        mul_b = 2'b00;
        if (state == RUN) begin
            mul_a = a_reg[{i_idx, 1'b0} +: 2];
            mul_b = b_reg[{j_idx, 1'b0} +: 2];
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            product <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        i_idx <= '0;
                        j_idx <= '0;
                    end else begin
                        acc <= acc_next;
                        if (last_step) begin
                            product <= acc_next;
                            state   <= DONE;
                            i_idx   <= '0;
                            j_idx   <= '0;
                        end else if (j_idx == LAST_IDX) begin
                            j_idx <= '0;
                            i_idx <= i_idx + 1'b1;
                        end else begin
                            j_idx <= j_idx + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
